// File: rtl/led_frame_buffer.sv
// Double-buffered DIM_X x DIM_Y LED frame store; back buffer is copied to the display on frame_sync after a commit.
// Optional blink masking is compiled in when LEDFB_BLINK_EN is defined.
module led_frame_buffer #(
    parameter int DIM_X        = 6,
    parameter int DIM_Y        = 6,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [2:0]             wr_row,
    input  logic [DIM_X-1:0]       wr_data,
    input  logic                   commit,
    input  logic                   frame_sync,
    output logic                   swap_pending,
    output logic                   wr_err,
    input  logic                   blink,
    output logic [DIM_X*DIM_Y-1:0] img
);

    localparam int NPIX = DIM_X * DIM_Y;

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [NPIX-1:0]   back_reg;
    logic [NPIX-1:0]   back_next;
    logic [NPIX-1:0]   front_reg;
    logic [NPIX-1:0]   img_reg;
    logic [NPIX-1:0]   img_next;
    logic              wr_err_reg;
    logic              accept;
    logic              row_bad;
    logic              swap;

    assign accept  = wr_valid && wr_ready;
    assign row_bad = (int'(wr_row) >= DIM_Y);

    always_comb begin
        state_next   = state_reg;
        swap         = 1'b0;
        swap_pending = 1'b0;
        wr_ready     = 1'b1;
        case (state_reg)
            IDLE: begin
                if (commit) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                swap_pending = 1'b1;
                wr_ready     = 1'b0;
                if (frame_sync) begin
                    state_next = IDLE;
                    swap       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Each row slice of the back buffer is replaced only by a write addressed to it.
    genvar gi;
    generate
        for (gi = 0; gi < DIM_Y; gi++) begin : g_row
            assign back_next[gi*DIM_X +: DIM_X] =
                (accept && (wr_row == 3'(gi))) ? wr_data : back_reg[gi*DIM_X +: DIM_X];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            back_reg   <= '0;
            front_reg  <= '0;
            img_reg    <= '0;
            wr_err_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            back_reg   <= back_next;
            wr_err_reg <= accept && row_bad;
            img_reg    <= img_next;
            if (swap) begin
                front_reg <= back_reg;
            end
        end
    end

`ifdef LEDFB_BLINK_EN
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0] blink_cnt_reg;
    logic             phase_on_reg;

    // Blink cadence is tied to frame pulses, independent of buffer swaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_reg <= '0;
            phase_on_reg  <= 1'b1;
        end else if (!blink) begin
            blink_cnt_reg <= '0;
            phase_on_reg  <= 1'b1;
        end else if (frame_sync) begin
            if (blink_cnt_reg == CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_reg <= '0;
                phase_on_reg  <= !phase_on_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
        end
    end

    assign img_next = (blink && !phase_on_reg) ? '0 : front_reg;
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic unused_blink;
    assign unused_blink = blink;
    assign img_next     = front_reg;
`endif

    assign img    = img_reg;
    assign wr_err = wr_err_reg;

endmodule

// File: doc/led_frame_buffer.md
# led_frame_buffer

Double-buffered 6x6 frame store that sits directly upstream of the LED matrix scanner and drives its 36-bit `img` input. Producers write rows into a back buffer over a valid/ready port, then request a commit. The block copies the back buffer to the displayed front buffer only on a frame-boundary pulse from the scanner, so a frame is never shown half-updated.

## Interface
- `DIM_X`, default 6: columns per row (bits per write word).
- `DIM_Y`, default 6: rows.
- `BLINK_FRAMES`, default 30: frame_sync pulses per blink half-period. Used only with `LEDFB_BLINK_EN`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  row write request.
- `wr_ready`  out  1  block can accept a write; equals `!swap_pending`.
- `wr_row`  in  3  target row, 0..DIM_Y-1.
- `wr_data`  in  DIM_X  row pixels, 1 = LED on. Bit c maps to img bit (wr_row*DIM_X + c).
- `commit`  in  1  single-cycle pulse requesting a back-to-front copy.
- `frame_sync`  in  1  single-cycle pulse at the scanner's row wrap (row DIM_Y-1 to 0).
- `swap_pending`  out  1  a commit is waiting for frame_sync.
- `wr_err`  out  1  one-cycle pulse when an accepted write had an out-of-range `wr_row`.
- `blink`  in  1  blink enable. Ignored unless `LEDFB_BLINK_EN` is defined.
- `img`  out  DIM_X*DIM_Y  displayed image, registered.

## Operation
- **Storage:** `back` and `front` registers, each DIM_X*DIM_Y bits.
- **Write acceptance:** a write is accepted on a clock edge where `wr_valid && wr_ready`.
  - `wr_row < DIM_Y`: the corresponding DIM_X-bit slice of `back` is replaced. All other bits are unchanged.
  - `wr_row >= DIM_Y`: the handshake completes, `back` is unchanged, and `wr_err` is 1 for the next cycle.
- **FSM states:**
  - IDLE: `swap_pending`=0.
  - PENDING: `swap_pending`=1.
- **FSM transitions:**
  - IDLE to PENDING on `commit`. A write accepted in the same cycle as `commit` is included in the committed frame.
  - PENDING to IDLE on `frame_sync`, with `front <= back` on that same edge.
  - `commit` while in PENDING is ignored.
  - `frame_sync` while in IDLE is ignored.
- **Swap timing:** `frame_sync` in the same cycle as `commit`, from IDLE, does not swap. The swap occurs at the next `frame_sync` strictly after the commit cycle.
- **Copy semantics:** `back` keeps its contents after a swap, so producers can do incremental updates.
- **Write back-pressure:** while PENDING, `wr_ready`=0 and no write is accepted. `back` is frozen until the swap.
- **Image output:** `img` is registered from `front`, and from the blink mask when that feature is enabled.

## Timing
- **Reset (`rst_n`=0, asynchronous):**
  - `back`=0, `front`=0, `img`=0.
  - State IDLE, `swap_pending`=0, `wr_ready`=1, `wr_err`=0.
  - Blink counter = 0, phase = on.
- **Reset mid-operation:** all of the above, immediately. A pending commit is lost.
- **Write latency:** `back` updates on the accept edge.
- **Commit latency:** `swap_pending` rises on the edge after `commit`. `wr_ready` falls combinationally with it.
- **Display latency:** `front` updates on the `frame_sync` edge, and `img` reflects it one cycle later. In PENDING, the total from `frame_sync` to new `img` is 2 edges.
- **Throughput:** one row write per cycle in IDLE.
- **Ready after swap:** `wr_ready` returns to 1 the cycle after the swap edge.

## Configuration
- `LEDFB_BLINK_EN` defined:
  - A counter of width clog2(BLINK_FRAMES) counts `frame_sync` pulses while `blink`=1.
  - When it reaches BLINK_FRAMES-1 it wraps to 0 and toggles the phase.
  - `img` = `front` when the phase is on, and 0 when off.
  - `blink`=0 forces the counter to 0, the phase to on, and `img` = `front`.
  - A front-buffer swap does not reset the blink phase.
- `LEDFB_BLINK_EN` undefined: the counter and phase logic are absent, `blink` is unused, and `img` = `front` registered.

## Test plan
- **Reset and single-row write:**
  - Stimulus: release reset, write row 2 = 6'b101101, pulse `commit`, then pulse `frame_sync` 10 cycles later.
  - Before the swap: `img` stays 0 and `swap_pending` is 1.
  - After the swap: `img[17:12]` = 6'b101101 two edges after `frame_sync`, all other bits 0, and `wr_ready` returns to 1.
- **Same-cycle commit and frame_sync:**
  - Stimulus: pulse `commit` and `frame_sync` together, then `frame_sync` again 50 cycles later.
  - Required: no swap on the first pulse; swap on the second.
- **Back-pressure:**
  - Stimulus: hold `wr_valid` while PENDING with `wr_row`=0, `wr_data`=6'h3F.
  - Required: not accepted until after the swap. It is then accepted on the first cycle with `wr_ready`=1, and the prior frame's `img[5:0]` is unchanged until the next commit.
- **Out-of-range row:**
  - Stimulus: write `wr_row`=7 with `wr_data`=6'h3F, then commit and swap.
  - Required: `wr_err` pulses once and `img` is unchanged.
- **Reset mid-operation:**
  - Stimulus: assert `rst_n` low while PENDING.
  - Required: immediately `swap_pending`=0 and `img`=0. A later `frame_sync` causes no swap.
- **Blink (`LEDFB_BLINK_EN` defined, BLINK_FRAMES=2):**
  - Stimulus: `front`=all ones, `blink`=1.
  - Required: `img` alternates between 36'hFFFFFFFFF and 0 every 2 `frame_sync` pulses.
  - Stimulus: `blink`=0.
  - Required: `img` returns to 36'hFFFFFFFFF on the next cycle.
